// File: rtl/gate_model_bist_ctrl.sv
// BIST controller for a combinational gate model. It drives an LFSR pattern
// onto the model inputs, holds each pattern for SETTLE cycles, compacts the
// model response into a 16-bit MISR, and compares the final signature with
// a golden value.
module gate_model_bist_ctrl #(
  parameter int SETTLE = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] pat_count,
  input  logic [20:0] seed,
  input  logic [15:0] golden,
  output logic [20:0] vec,
  input  logic [9:0]  resp,
  output logic        busy,
  output logic        done,
  output logic [15:0] signature,
  output logic        pass
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_APPLY   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_FINISH  = 3'd4
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t      state_q, state_d;
  logic [20:0] vec_q, vec_d;
  logic [20:0] seed_q, seed_d;
  logic [15:0] count_q, count_d;
  logic [15:0] sig_q, sig_d;
  logic [3:0]  settle_q, settle_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;

  // MISR step with feedback polynomial 0x1021 and the response folded in
  function automatic logic [15:0] misr_next(input logic [15:0] sig, input logic [9:0] r);
    misr_next = {sig[14:0], 1'b0} ^ (sig[15] ? 16'h1021 : 16'h0000) ^ {6'b000000, r};
  endfunction

  // Fibonacci LFSR step for x^21 + x^19 + 1
  function automatic logic [20:0] lfsr_next(input logic [20:0] v);
    lfsr_next = {v[19:0], v[20] ^ v[18]};
  endfunction

  // Next-state and next-output computation for the whole controller
  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    seed_d   = seed_q;
    count_d  = count_q;
    sig_d    = sig_q;
    settle_d = settle_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    pass_d   = pass_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          busy_d  = 1'b1;
          count_d = pat_count;
          seed_d  = seed;
        end else begin
          busy_d  = 1'b0;
        end
      end
      ST_LOAD: begin
        // An all-zero seed would lock the LFSR, so substitute 1
        vec_d    = (seed_q == 21'd0) ? 21'h000001 : seed_q;
        sig_d    = 16'h0000;
        pass_d   = 1'b0;
        settle_d = 4'd0;
        if (count_q == 16'd0) begin
          state_d = ST_FINISH;
          busy_d  = 1'b0;
        end else begin
          state_d = ST_APPLY;
          busy_d  = 1'b1;
        end
      end
      ST_APPLY: begin
        if (settle_q == SETTLE_LAST) begin
          state_d  = ST_CAPTURE;
          settle_d = 4'd0;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end
      ST_CAPTURE: begin
        sig_d   = misr_next(sig_q, resp);
        vec_d   = lfsr_next(vec_q);
        count_d = count_q - 16'd1;
        // count_q == 1 means the decremented count reaches zero
        if (count_q == 16'd1) begin
          state_d = ST_FINISH;
          busy_d  = 1'b0;
        end else begin
          state_d = ST_APPLY;
          busy_d  = 1'b1;
        end
      end
      ST_FINISH: begin
        done_d  = 1'b1;
        pass_d  = (sig_q == golden);
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      vec_q    <= 21'd0;
      seed_q   <= 21'd0;
      count_q  <= 16'd0;
      sig_q    <= 16'h0000;
      settle_q <= 4'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      seed_q   <= seed_d;
      count_q  <= count_d;
      sig_q    <= sig_d;
      settle_q <= settle_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
    end
  end

  assign vec       = vec_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign signature = sig_q;
  assign pass      = pass_q;

endmodule

// File: tb/tb_gate_model_bist_ctrl.sv
// Self-checking bench for gate_model_bist_ctrl: directed table, hand-written
// corner sequences and randomized runs against a behavioural model.
module tb_gate_model_bist_ctrl;

  localparam int S = 2;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] pat_count;
  logic [20:0] seed;
  logic [15:0] golden;
  logic [20:0] vec;
  logic [9:0]  resp;
  logic        busy;
  logic        done;
  logic [15:0] signature;
  logic        pass;

  logic        resp_tied;
  logic [9:0]  resp_const;
  logic [9:0]  resp_mask;

  int n_checks;
  int n_fail;

  gate_model_bist_ctrl #(.SETTLE(S)) dut (
    .clk(clk), .rst(rst), .start(start), .pat_count(pat_count), .seed(seed),
    .golden(golden), .vec(vec), .resp(resp), .busy(busy), .done(done),
    .signature(signature), .pass(pass)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in gate model: a fixed mixing function of the stimulus
  function automatic logic [9:0] gate_fn(input logic [20:0] v, input logic [9:0] m);
    gate_fn = v[9:0] ^ v[19:10] ^ {9'd0, v[20]} ^ m;
  endfunction

  always_comb begin
    if (resp_tied) resp = resp_const;
    else           resp = gate_fn(vec, resp_mask);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: list of patterns a run applies (polynomial x^21+x^19+1)
  function automatic void model_vecs(input int p, input logic [20:0] sd, output logic [20:0] q[$]);
    int unsigned v;
    q = {};
    v = (sd == 21'd0) ? 1 : int'(sd);
    for (int i = 0; i < p; i++) begin
      q.push_back(21'(v));
      v = ((v << 1) | (((v >> 20) ^ (v >> 18)) & 1)) & 32'h1FFFFF;
    end
  endfunction

  // Reference signature: polynomial division of the response stream
  function automatic logic [15:0] model_sig(input int p, input logic [20:0] sd,
                                            input bit tied, input logic [9:0] rc,
                                            input logic [9:0] m);
    logic [20:0] q[$];
    int unsigned s;
    int unsigned r;
    model_vecs(p, sd, q);
    s = 0;
    foreach (q[i]) begin
      r = tied ? int'(rc) : int'(gate_fn(q[i], m));
      s = s * 2;
      if (s >= 32'h10000) s = (s - 32'h10000) ^ 32'h1021;
      s = s ^ r;
    end
    return 16'(s);
  endfunction

  task automatic run(input string name, input logic [15:0] pc, input logic [20:0] sd,
                     input logic [15:0] gold, input bit tied, input logic [9:0] rc,
                     input logic [9:0] m, input logic [15:0] exp_sig, input bit exp_pass,
                     input int exp_done);
    logic [20:0] q[$];
    int k;
    int j;
    bit got;
    logic [15:0] sig_hold;
    logic [20:0] vec_hold;
    model_vecs(int'(pc), sd, q);
    @(negedge clk);
    pat_count = pc; seed = sd; golden = gold;
    resp_tied = tied; resp_const = rc; resp_mask = m;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({name, "_busy_load"}, 32'(busy), 32'd1);
    got = 1'b0;
    k = 0;
    while (!got && k < exp_done + 20) begin
      @(posedge clk); #1;
      k++;
      if (k < exp_done) check({name, "_busy"}, 32'(busy), 32'(k < exp_done - 1));
      if (k < exp_done - 1 && pc != 16'd0) begin
        j = (k - 1) / (S + 1);
        check({name, "_vec"}, 32'(vec), 32'(q[j]));
      end
      if (done) got = 1'b1;
    end
    check({name, "_done_seen"}, 32'(got), 32'd1);
    check({name, "_done_cycle"}, k, exp_done);
    check({name, "_sig"}, 32'(signature), 32'(exp_sig));
    check({name, "_pass"}, 32'(pass), 32'(exp_pass));
    sig_hold = signature;
    vec_hold = vec;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check({name, "_idle_done"}, 32'(done), 32'd0);
      check({name, "_idle_busy"}, 32'(busy), 32'd0);
      check({name, "_idle_sig"}, 32'(signature), 32'(sig_hold));
      check({name, "_idle_vec"}, 32'(vec), 32'(vec_hold));
    end
  endtask

  typedef struct {
    string       name;
    logic [15:0] pc;
    logic [20:0] sd;
    logic [9:0]  rc;
    logic [15:0] gold;
    logic [15:0] exp_sig;
    bit          exp_pass;
    int          exp_done;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int dn;
    int k;
    logic [15:0] pc;
    logic [20:0] sd;
    logic [9:0]  m;
    logic [15:0] s;
    logic [15:0] g;

    n_checks = 0;
    n_fail   = 0;
    tbl[0] = '{"p0",         16'd0, 21'h000005, 10'h000, 16'h0000, 16'h0000, 1'b1, 2};
    tbl[1] = '{"p1_seed0",   16'd1, 21'h000000, 10'h3FF, 16'h03FF, 16'h03FF, 1'b1, 5};
    tbl[2] = '{"p1_badgold", 16'd1, 21'h000123, 10'h3FF, 16'h03FE, 16'h03FF, 1'b0, 5};
    tbl[3] = '{"p4_zero",    16'd4, 21'h000001, 10'h000, 16'h0000, 16'h0000, 1'b1, 14};
    tbl[4] = '{"p2_ones",    16'd2, 21'h000007, 10'h3FF, 16'h0401, 16'h0401, 1'b1, 8};
    tbl[5] = '{"p8_fb",      16'd8, 21'h1ABCDE, 10'h3FF, 16'h4474, 16'h4474, 1'b1, 26};

    rst = 1'b1; start = 1'b0; pat_count = 16'd0; seed = 21'd0; golden = 16'd0;
    resp_tied = 1'b1; resp_const = 10'd0; resp_mask = 10'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_vec",  32'(vec), 32'd0);
    check("rst_sig",  32'(signature), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);

    // Reset wins over start in the same cycle
    start = 1'b1; pat_count = 16'd3;
    @(posedge clk); #1;
    check("rst_prio_busy", 32'(busy), 32'd0);
    start = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    check("rst_prio_idle", 32'(busy), 32'd0);

    for (int i = 0; i < 6; i++)
      run(tbl[i].name, tbl[i].pc, tbl[i].sd, tbl[i].gold, 1'b1, tbl[i].rc, 10'd0,
          tbl[i].exp_sig, tbl[i].exp_pass, tbl[i].exp_done);

    // Reset during the third APPLY cycle of a 10-pattern run
    @(negedge clk);
    pat_count = 16'd10; seed = 21'h00F00D; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_vec",  32'(vec), 32'd0);
    check("midrst_sig",  32'(signature), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    dn = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (done) dn++;
    end
    check("midrst_no_done", dn, 0);

    // start held high while busy and during FINISH is ignored
    @(negedge clk);
    pat_count = 16'd3; seed = 21'h000011; golden = 16'd0;
    resp_tied = 1'b1; resp_const = 10'h155; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dn = 0;
    k = 0;
    for (int i = 1; i <= 45; i++) begin
      @(posedge clk); #1;
      start = (i >= 2 && i < 11);
      if (done) begin
        dn++;
        k = i;
      end
    end
    start = 1'b0;
    check("reassert_one_done", dn, 1);
    check("reassert_done_cycle", k, 11);
    check("reassert_busy_after", 32'(busy), 32'd0);

    // Randomized runs against the behavioural model
    for (int r = 0; r < 6; r++) begin
      pc = 16'($urandom_range(1, 12));
      sd = 21'($urandom);
      m  = 10'($urandom);
      s  = model_sig(int'(pc), sd, 1'b0, 10'd0, m);
      g  = (r % 2 == 1) ? s : 16'($urandom);
      run("rand", pc, sd, g, 1'b0, 10'd0, m, s, (g == s), int'(pc) * (S + 1) + 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gate_model_bist_ctrl.md
GATE_MODEL_BIST_CTRL -- requirements
Module: gate_model_bist_ctrl

Interface
REQ-001 SHALL provide parameter SETTLE, default 2: cycles each pattern is held before capture; legal range 1..15.
REQ-002 SHALL provide port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 SHALL provide port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL provide port start, input, 1: run request, sampled in IDLE only.
REQ-005 SHALL provide port pat_count, input, 16: number of patterns to apply, sampled with start.
REQ-006 SHALL provide port seed, input, 21: LFSR start value, sampled with start.
REQ-007 SHALL provide port golden, input, 16: expected signature, sampled in FINISH.
REQ-008 SHALL provide port vec, output, 21: stimulus to gate model inputs N1..N21 (vec[0]=N1).
REQ-009 SHALL provide port resp, input, 10: gate model outputs in order N195,N219,N204,N220,N215,N216,N217,N213,N205,N221 (resp[0]=N195).
REQ-010 SHALL provide port busy, output, 1: run in progress.
REQ-011 SHALL provide port done, output, 1: single-cycle run-complete pulse.
REQ-012 SHALL provide port signature, output, 16: MISR contents.
REQ-013 SHALL provide port pass, output, 1: signature == golden, valid from done.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, APPLY, CAPTURE, FINISH; all outputs registered.
REQ-015 SHALL, in IDLE with start=1, go to LOAD; start in any other state is ignored.
REQ-016 SHALL, in LOAD, set vec=seed (seed==0 replaced by 21'h000001), signature=0, pass=0, count=pat_count, settle counter=0.
REQ-017 SHALL go LOAD->FINISH if pat_count==0, else LOAD->APPLY.
REQ-018 SHALL hold vec stable for exactly SETTLE cycles in APPLY, then go to CAPTURE.
REQ-019 SHALL, in CAPTURE, update MISR: next = {sig[14:0],0} ^ (sig[15] ? 16'h1021 : 0) ^ {6'b0,resp}.
REQ-020 SHALL, in CAPTURE, advance LFSR: vec_next = {vec[19:0], vec[20]^vec[18]} (x^21+x^19+1), and decrement count.
REQ-021 SHALL go CAPTURE->FINISH when the decremented count is 0, else CAPTURE->APPLY.
REQ-022 SHALL, in FINISH, assert done for one cycle, register pass = (signature==golden), then go to IDLE.
REQ-023 SHALL assert busy in LOAD, APPLY and CAPTURE only; low in IDLE and FINISH.
REQ-024 SHALL assert done exactly P*(SETTLE+1)+2 cycles after the cycle in which start was sampled (P = pat_count).
REQ-025 SHALL hold signature, pass and vec unchanged in IDLE until the next LOAD.
REQ-026 SHALL accept pat_count=16'hFFFF without wrap or early termination.
REQ-027 SHALL not evaluate start in FINISH; back-to-back runs need start high in IDLE.

Reset
REQ-028 SHALL, on rst=1 at a clock edge, force IDLE, vec=0, signature=0, busy=0, done=0, pass=0, from any state including mid-run.
REQ-029 SHALL give rst priority over start in the same cycle.

Verification
REQ-030 pat_count=0, golden=0, start -> done pulse 2 cycles later, signature=16'h0000, pass=1, busy never high after LOAD.
REQ-031 pat_count=1, seed=0, resp tied 10'h3FF, SETTLE=2 -> vec=21'h000001 for 2 APPLY cycles, done at cycle 5, signature=16'h03FF.
REQ-032 pat_count=1, resp tied 10'h3FF, golden=16'h03FE -> pass=0 on done.
REQ-033 pat_count=4, seed=21'h000001, resp tied 0 -> vec sequence 000001,000002,000004,000008, signature=0, done at cycle 14.
REQ-034 rst pulsed during third APPLY cycle of a 10-pattern run -> next cycle busy=0, vec=0, signature=0; no done pulse follows.
REQ-035 start re-asserted while busy and in FINISH -> ignored; exactly one done per run; new run starts only on start sampled in IDLE.
